// File: rtl/text_renderer.sv
// MDA text-mode pixel generator: walks the 80x25 character grid, fetches codes and glyph rows,
// serialises 9-pixel cells with a blinking underline cursor, and keeps sync aligned (3-cycle latency).
module text_renderer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 25,
  parameter int CHAR_W    = 9,
  parameter int CHAR_H    = 14,
  parameter int BLINK_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_active,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        in_frame_start,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [10:0] ram_addr,
  input  logic [7:0]  ram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        video,
  output logic        intensity,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [3:0]  PX_LAST   = 4'(CHAR_W - 1);
  localparam logic [3:0]  SCAN_LAST = 4'(CHAR_H - 1);
  localparam logic [3:0]  CUR_SCAN  = 4'(CHAR_H - 2);
  localparam logic [6:0]  COL_END   = 7'(COLS);
  localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]  ROW_END   = 5'(ROWS);
  localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
  localparam logic [10:0] ROW_STEP  = 11'(COLS);

  logic [3:0]  px, px_n;
  logic [6:0]  col, col_n, col_addr;
  logic [3:0]  scan, scan_n;
  logic [4:0]  row, row_n;
  logic [10:0] row_base, row_base_n;
  logic [7:0]  frame_cnt, frame_cnt_n;
  logic        prev_active;

  logic        valid0, hit0;
  logic [3:0]  s1_px, s1_scan, s2_px;
  logic        s1_active, s1_valid, s1_hit, s1_hs, s1_vs;
  logic        s2_active, s2_valid, s2_hit, s2_hs, s2_vs, s2_ext;
  logic        pix;

  always_comb begin
    px_n        = px;
    col_n       = col;
    scan_n      = scan;
    row_n       = row;
    row_base_n  = row_base;
    frame_cnt_n = frame_cnt;
    if (in_frame_start) begin
      px_n        = '0;
      col_n       = '0;
      scan_n      = '0;
      row_n       = '0;
      row_base_n  = '0;
      frame_cnt_n = frame_cnt + 8'd1;
    end else if (in_active) begin
      if (px == PX_LAST) begin
        px_n = '0;
        if (col != COL_END) col_n = col + 7'd1;
      end else begin
        px_n = px + 4'd1;
      end
    end else if (prev_active) begin
      px_n  = '0;
      col_n = '0;
      if (scan == SCAN_LAST) begin
        scan_n = '0;
        if (row != ROW_END) row_n = row + 5'd1;
        // row_base stops at the last row so the address never leaves the 2000-byte RAM
        if (row < ROW_LAST) row_base_n = row_base + ROW_STEP;
      end else begin
        scan_n = scan + 4'd1;
      end
    end
  end

  assign col_addr = (col_n >= COL_END) ? COL_LAST : col_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      px          <= '0;
      col         <= '0;
      scan        <= '0;
      row         <= '0;
      row_base    <= '0;
      frame_cnt   <= '0;
      prev_active <= 1'b0;
      ram_addr    <= '0;
    end else begin
      px          <= px_n;
      col         <= col_n;
      scan        <= scan_n;
      row         <= row_n;
      row_base    <= row_base_n;
      frame_cnt   <= frame_cnt_n;
      prev_active <= in_active;
      ram_addr    <= row_base_n + {4'b0000, col_addr};
    end
  end

  assign valid0 = (col < COL_END) && (row < ROW_END);
  assign hit0   = cursor_en && (col == cursor_col) && (row == cursor_row) &&
                  (scan >= CUR_SCAN) && !frame_cnt[BLINK_BIT];

  assign font_addr = {ram_data, s1_scan};

  // Extension column repeats the rightmost glyph bit only for line-drawing codes 0xC0..0xDF.
  always_comb begin
    pix = 1'b0;
    if (!s2_px[3]) pix = font_data[~s2_px[2:0]];
    else if (s2_ext) pix = font_data[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_px     <= '0;
      s1_scan   <= '0;
      s1_active <= 1'b0;
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b1;
      s2_px     <= '0;
      s2_active <= 1'b0;
      s2_valid  <= 1'b0;
      s2_hit    <= 1'b0;
      s2_ext    <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b1;
      video     <= 1'b0;
      intensity <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b1;
    end else begin
      s1_px     <= px;
      s1_scan   <= scan;
      s1_active <= in_active;
      s1_valid  <= valid0;
      s1_hit    <= hit0;
      s1_hs     <= in_hsync;
      s1_vs     <= in_vsync;
      s2_px     <= s1_px;
      s2_active <= s1_active;
      s2_valid  <= s1_valid;
      s2_hit    <= s1_hit;
      s2_ext    <= (ram_data[7:5] == 3'b110);
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      video     <= s2_active && s2_valid && (pix || s2_hit);
      intensity <= s2_active && s2_valid && s2_hit;
      hsync     <= s2_hs;
      vsync     <= s2_vs;
    end
  end

endmodule
